// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start-edge detect with baud
// generator re-phase pulse, and a tick-driven frame FSM
// (start / data / optional parity / stop).
module uart_rx #(
  parameter int UART_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  output logic                 phase_accum_reset,
  output logic [UART_SIZE-1:0] rx_data,
  input  logic                 parity_enable,
  input  logic                 parity_type,
  output logic                 crc_error,
  output logic                 stop_error,
  input  logic                 RX
);

  // Counter holds 0..UART_SIZE-1 data-bit indices.
  localparam int CW = (UART_SIZE < 2) ? 1 : $clog2(UART_SIZE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 fall;
  logic [UART_SIZE-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]        bit_cnt;
  logic                 pen_l, ptype_l, par_err;

  // Synchroniser plus history flop; preset high so reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall = rx_prev & ~rx_s2;

  // New bit enters at the MSB so the first bit received ends up at bit 0.
  if (UART_SIZE == 1) begin : g_shift1
    assign shift_nxt = rx_s2;
  end else begin : g_shiftn
    assign shift_nxt = {rx_s2, shift_reg[UART_SIZE-1:1]};
  end

  // Frame FSM; outputs update only when a stop bit is sampled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      rx_data           <= '0;
      crc_error         <= 1'b0;
      stop_error        <= 1'b0;
      phase_accum_reset <= 1'b0;
      shift_reg         <= '0;
      bit_cnt           <= '0;
      pen_l             <= 1'b0;
      ptype_l           <= 1'b0;
      par_err           <= 1'b0;
    end else begin
      phase_accum_reset <= 1'b0;
      case (state)
        IDLE: begin
          // Ticks are ignored here; only a fresh falling edge starts a frame.
          if (fall) begin
            phase_accum_reset <= 1'b1;
            pen_l             <= parity_enable;
            ptype_l           <= parity_type;
            state             <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            if (!rx_s2) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;  // glitch, not a real start bit
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(UART_SIZE - 1))
              state <= pen_l ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (baud_tick) begin
            // Even: required bit is XOR of data; odd: its inverse.
            par_err <= rx_s2 ^ (ptype_l ? ^shift_reg : ~^shift_reg);
            state   <= STOP;
          end
        end
        STOP: begin
          if (baud_tick) begin
            rx_data    <= shift_reg;
            stop_error <= ~rx_s2;
            crc_error  <= pen_l & par_err;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized frames against a frame-level reference model.
module tb_uart_rx;
  localparam int W    = 8;
  localparam int HALF = 128;  // half bit period in clocks

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         baud_tick = 1'b0;
  logic         parity_enable = 1'b0;
  logic         parity_type = 1'b0;
  logic         rx = 1'b1;
  logic         phase_accum_reset;
  logic [W-1:0] rx_data;
  logic         crc_error, stop_error;

  uart_rx #(.UART_SIZE(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .baud_tick         (baud_tick),
    .phase_accum_reset (phase_accum_reset),
    .rx_data           (rx_data),
    .parity_enable     (parity_enable),
    .parity_type       (parity_type),
    .crc_error         (crc_error),
    .stop_error        (stop_error),
    .RX                (rx)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0, pulses = 0;
  logic [W-1:0] exp_data = '0;
  logic         exp_crc = 1'b0, exp_stop = 1'b0;

  // Count cycles during which the re-phase strobe is high.
  always @(negedge clk) if (phase_accum_reset === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'(exp_data));
    chk({tag, "_crc"},  32'(crc_error), 32'(exp_crc));
    chk({tag, "_stop"}, 32'(stop_error), 32'(exp_stop));
  endtask

  // Parity bit is wrong if total ones (data + parity) has the wrong evenness.
  function automatic logic parity_bad(input logic [W-1:0] d, input logic ptype, input logic pb);
    int ones;
    ones = $countones(d) + int'(pb);
    return ptype ? (ones % 2 != 0) : (ones % 2 != 1);
  endfunction

  // One bit period, tick at mid-bit; coin adds a tick on the edge-detect cycle.
  task automatic slot(input logic b, input bit coin);
    rx = b;
    for (int c = 0; c < HALF; c++) begin
      baud_tick = coin && (c == 2);
      @(negedge clk);
    end
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic ptype,
                            input logic pb, input logic sb, input bit coin);
    int p0;
    p0 = pulses;
    parity_enable = pen;
    parity_type   = ptype;
    slot(1'b0, coin);
    // Config is latched at the start edge; scramble it for the rest of the frame.
    parity_enable = 1'($urandom);
    parity_type   = 1'($urandom);
    for (int i = 0; i < W; i++) slot(d[i], 1'b0);
    if (pen) slot(pb, 1'b0);
    rx = sb;
    repeat (HALF) @(negedge clk);
    chk_outs("hold");
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    exp_data = d;
    exp_stop = ~sb;
    exp_crc  = pen && parity_bad(d, ptype, pb);
    chk_outs("frame");
    repeat (HALF - 1) @(negedge clk);
    if (!sb) repeat (40) @(negedge clk);  // line stays low: must not retrigger
    chk("pulse", 32'(pulses - p0), 32'd1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int p0;
    logic [W-1:0] d;
    logic pen, ptype, pb, sb;

    repeat (10) @(negedge clk);
    chk_outs("reset");
    chk("reset_par", 32'(phase_accum_reset), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h65, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);  // bits 1,0,1,0,0,1,1,0
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // even, good
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);  // even, bad
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // odd, good
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);  // odd, bad
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // stop error
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // False start: low 100 clocks, back high before the mid-bit tick.
    p0 = pulses;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (HALF - 100) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    repeat (20) @(negedge clk);
    chk("false_pulse", 32'(pulses - p0), 32'd1);
    chk_outs("false");
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after four data bits of 0x3C.
    slot(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) slot(logic'((8'h3C >> i) & 8'h01), 1'b0);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    exp_data = '0; exp_crc = 1'b0; exp_stop = 1'b0;
    chk_outs("midrst");
    chk("midrst_par", 32'(phase_accum_reset), 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 8; n++) begin
      d     = W'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      pb    = 1'($urandom);
      sb    = ($urandom_range(0, 3) != 0);
      send_frame(d, pen, ptype, pb, sb, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
